aes_decrypt_iterative: RTL and testbench

AES_DECRYPT_ITERATIVE -- requirements
Module: aes_decrypt_iterative

---
 rtl/aes_decrypt_iterative_if.sv | 12 +
 rtl/aes_decrypt_iterative.sv | 175 +++++++++++++++++
 tb/tb_aes_decrypt_iterative.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_decrypt_iterative_if.sv
// Request/result bundle for the iterative AES-128 decryptor.
interface aes_decrypt_iterative_if;
  logic         start;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;
  logic         done;
  logic         busy;

  modport master (output start, data_in, key_in, input data_out, done, busy);
  modport slave  (input start, data_in, key_in, output data_out, done, busy);
endinterface

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryptor: expands the key forward into rk[0..10] each block,
// then runs the inverse cipher one round per cycle from rk[10] down to rk[0].
module aes_decrypt_iterative (
  input  logic                     clk,
  input  logic                     reset,
  aes_decrypt_iterative_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, FINAL} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt, rnd;
  logic [127:0]  st;
  logic [127:0]  rk [0:10];
  logic [127:0]  data_out_q;
  logic          done_q, busy_q;

  logic [127:0]  key_prev, key_next, inv_sr, inv_sb, add_rk, inv_mc;
  logic [31:0]   temp;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, t;
    p = 8'h01;
    t = a;
    for (int k = 1; k < 8; k++) begin
      t = gf_mul(t, t);
      p = gf_mul(p, t);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Forward key schedule step: rk[cnt] from rk[cnt-1].
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    key_prev = rk[0];
    if (cnt inside {[4'd1:4'd10]}) key_prev = rk[cnt - 4'd1];
    temp = {sbox(key_prev[23:16]), sbox(key_prev[15:8]), sbox(key_prev[7:0]), sbox(key_prev[31:24])}
           ^ {rcon(cnt), 24'h000000};
    key_next[127:96] = key_prev[127:96] ^ temp;
    key_next[95:64]  = key_prev[95:64]  ^ key_next[127:96];
    key_next[63:32]  = key_prev[63:32]  ^ key_next[95:64];
    key_next[31:0]   = key_prev[31:0]   ^ key_next[63:32];
  end

  // Inverse round datapath; byte (r,c) lives at index 4*c+r, byte 0 in the MSBs.
  always_comb begin
    inv_sr = '0;
    inv_sb = '0;
    inv_mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        inv_sr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      inv_sb[127-8*i -: 8] = inv_sbox(inv_sr[127-8*i -: 8]);
    end
    add_rk = inv_sb ^ rk[rnd];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        inv_mc[127-8*(4*c+r) -: 8] = gf_mul(add_rk[127-8*(4*c+r)       -: 8], 8'h0e)
                                   ^ gf_mul(add_rk[127-8*(4*c+(r+1)%4) -: 8], 8'h0b)
                                   ^ gf_mul(add_rk[127-8*(4*c+(r+2)%4) -: 8], 8'h0d)
                                   ^ gf_mul(add_rk[127-8*(4*c+(r+3)%4) -: 8], 8'h09);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = KEXP;
      KEXP:    if (cnt == 4'd10) state_d = ROUND;
      ROUND:   if (rnd == 4'd1) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= 4'd0;
      rnd        <= 4'd0;
      st         <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      // NOTE: the round-key file is cleared on reset so no key material outlives an abort.
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          st     <= bus.data_in;
          rk[0]  <= bus.key_in;
          cnt    <= 4'd1;
          busy_q <= 1'b1;
        end
        KEXP: begin
          rk[cnt] <= key_next;
          if (cnt == 4'd10) begin
            st  <= st ^ key_next;
            rnd <= 4'd9;
            cnt <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          st  <= inv_mc;
          rnd <= rnd - 4'd1;
        end
        FINAL: begin
          data_out_q <= add_rk;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Self-checking bench for aes_decrypt_iterative: known-answer vectors, a forward AES
// reference for random back-to-back blocks, and abort/ignore/scramble scenarios.
module tb_aes_decrypt_iterative;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] L_KEY  = 128'h000102030405063923090a0b0c0d0e0f;
  localparam logic [127:0] L_CT   = 128'h0cdc3c906675d9081510b9083d9c13e3;
  localparam logic [127:0] L_PT   = 128'h0011223344556677ff99aabbfcddeeff;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_decrypt_iterative_if bus();
  aes_decrypt_iterative dut (.clk(clk), .reset(reset), .bus(bus));

  int n_assert   = 0;
  int n_fail     = 0;
  int done_count = 0;
  logic [127:0] sb [$];
  logic [7:0]   sbox_t [256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Forward S-box built by walking the field with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k, t, m;
    logic [31:0]  w;
    logic [7:0]   rc;
    logic [7:0]   a [4];
    s  = pt ^ key;
    k  = key;
    rc = 8'h01;
    for (int rd = 1; rd <= 10; rd++) begin
      w = {k[23:0], k[31:24]};
      w = {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]} ^ {rc, 24'h0};
      k[127:96] = k[127:96] ^ w;
      k[95:64]  = k[95:64]  ^ k[127:96];
      k[63:32]  = k[63:32]  ^ k[95:64];
      k[31:0]   = k[31:0]   ^ k[63:32];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
      m = t;
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = t[127-8*(4*c+r) -: 8];
          for (int r = 0; r < 4; r++)
            m[127-8*(4*c+r) -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      s = m ^ k;
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Every done pulse retires the oldest expected plaintext.
  always @(negedge clk) begin : monitor
    logic [127:0] e;
    if (bus.done === 1'b1) begin
      e = 'x;
      if (sb.size() != 0) e = sb.pop_front();
      done_count++;
      check("plaintext", bus.data_out, e);
    end
  end

  // Called at a negedge; returns one negedge after the capture edge.
  task automatic start_block(input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] pt, input bit expect_done);
    bus.start   = 1'b1;
    bus.data_in = ct;
    bus.key_in  = key;
    if (expect_done) sb.push_back(pt);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_capture", 128'(bus.busy), 128'(1));
  endtask

  // Counts rising edges after capture until done; optionally scrambles inputs
  // or pulses start with another block at a given edge count.
  task automatic wait_done(input bit scramble, input int inject_at, output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 60) begin
      if (scramble) begin
        bus.data_in = rand128();
        bus.key_in  = rand128();
      end
      bus.start = (edges == inject_at);
      if (edges == inject_at) begin
        bus.data_in = B_CT;
        bus.key_in  = B_KEY;
      end
      @(negedge clk);
      edges++;
    end
    bus.start = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int dc;
    logic [127:0] pt, key;

    build_sbox();
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.key_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_data_out", bus.data_out, '0);
    check("reset_done", 128'(bus.done), '0);
    check("reset_busy", 128'(bus.busy), '0);
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 with latency, pulse width and hold
    start_block(C1_CT, C1_KEY, C1_PT, 1'b1);
    wait_done(1'b0, -1, lat);
    check("latency_c1", 128'(lat), 128'(20));
    check("busy_during_done", 128'(bus.busy), '0);
    @(negedge clk);
    check("done_one_cycle", 128'(bus.done), '0);
    repeat (5) @(negedge clk);
    check("data_out_hold", bus.data_out, C1_PT);

    // FIPS-197 Appendix B
    start_block(B_CT, B_KEY, B_PT, 1'b1);
    wait_done(1'b0, -1, lat);
    check("latency_appb", 128'(lat), 128'(20));
    @(negedge clk);

    // Loopback vector, then ten random blocks each started in the previous done cycle
    start_block(L_CT, L_KEY, L_PT, 1'b1);
    wait_done(1'b0, -1, lat);
    check("latency_loopback", 128'(lat), 128'(20));
    for (int k = 0; k < 10; k++) begin
      pt  = rand128();
      key = rand128();
      start_block(encrypt(pt, key), key, pt, 1'b1);
      wait_done(1'b0, -1, lat);
      check("latency_back_to_back", 128'(lat), 128'(20));
    end
    @(negedge clk);

    // Start pulsed mid-ROUND with another block is dropped
    dc = done_count;
    start_block(C1_CT, C1_KEY, C1_PT, 1'b1);
    wait_done(1'b0, 12, lat);
    check("latency_with_ignored_start", 128'(lat), 128'(20));
    repeat (30) @(negedge clk);
    check("single_done_pulse", 128'(done_count - dc), 128'(1));
    check("no_queued_block", 128'(bus.busy), '0);

    // Reset at cycle 12 aborts the block
    dc = done_count;
    start_block(B_CT, B_KEY, B_PT, 1'b0);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_data_out", bus.data_out, '0);
    check("abort_busy", 128'(bus.busy), '0);
    check("abort_done", 128'(bus.done), '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("no_done_after_abort", 128'(done_count - dc), '0);
    start_block(C1_CT, C1_KEY, C1_PT, 1'b1);
    wait_done(1'b0, -1, lat);
    check("latency_after_abort", 128'(lat), 128'(20));
    @(negedge clk);

    // Inputs scrambled every cycle after capture
    start_block(C1_CT, C1_KEY, C1_PT, 1'b1);
    wait_done(1'b1, -1, lat);
    check("latency_scrambled", 128'(lat), 128'(20));
    @(negedge clk);

    // Start held during reset is ignored
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.data_in = C1_CT;
    bus.key_in  = C1_KEY;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_reset_busy", 128'(bus.busy), '0);
    repeat (25) @(negedge clk);
    check("start_in_reset_data_out", bus.data_out, '0);
    check("scoreboard_empty", 128'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
